// File: rtl/bti_arb_if.sv
// BTI request and response channel interfaces.
// Request carries a command packet from host to guest; response carries the reply packet back.

interface bti_req_if_t #(
  parameter int unsigned BTI_AW = 32,
  parameter int unsigned BTI_DW = 32,
  parameter int unsigned BTI_TW = 4
);
  typedef struct packed {
    logic [BTI_TW-1:0]   tid;
    logic                cmd;
    logic [BTI_AW-1:0]   addr;
    logic [BTI_DW-1:0]   data;
    logic [BTI_DW/8-1:0] strobe;
  } pkt_t;

  logic vld;
  logic rdy;
  pkt_t pkt;

  modport mst (output vld, output pkt, input rdy);
  modport slv (input vld, input pkt, output rdy);
endinterface

interface bti_rsp_if_t #(
  parameter int unsigned BTI_DW = 32,
  parameter int unsigned BTI_TW = 4
);
  typedef struct packed {
    logic [BTI_TW-1:0] tid;
    logic [BTI_DW-1:0] data;
    logic              ok;
  } pkt_t;

  logic vld;
  logic rdy;
  pkt_t pkt;

  modport mst (output vld, output pkt, input rdy);
  modport slv (input vld, input pkt, output rdy);
endinterface

// File: rtl/bti_arb.sv
// Round-robin N-to-1 BTI arbiter with one outstanding transaction.
// A host is picked in IDLE, its request is forwarded in REQ, and the guest
// response is routed back to it in RSP before the next arbitration.

module bti_arb #(
  parameter int unsigned BTI_AW   = 32,
  parameter int unsigned BTI_DW   = 32,
  parameter int unsigned BTI_TW   = 4,
  parameter int unsigned HOST_NUM = 2
) (
  input logic      clk,
  input logic      rst_n,
  bti_req_if_t.slv host_bti_req_slvs [HOST_NUM],
  bti_rsp_if_t.mst host_bti_rsp_msts [HOST_NUM],
  bti_req_if_t.mst gst_bti_req_mst,
  bti_rsp_if_t.slv gst_bti_rsp_slv
);

  localparam int unsigned IdxW    = (HOST_NUM > 1) ? $clog2(HOST_NUM) : 1;
  localparam int unsigned ReqPktW = BTI_TW + 1 + BTI_AW + BTI_DW + BTI_DW / 8;

  typedef enum logic [1:0] {StIdle, StReq, StRsp} state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   grant_q, grant_d;
  logic [IdxW-1:0]   rr_ptr_q, rr_ptr_d;

  logic [HOST_NUM-1:0] host_vld;
  logic [HOST_NUM-1:0] host_rdy;
  logic [HOST_NUM-1:0] host_rsp_vld;
  logic [HOST_NUM-1:0] host_rsp_rdy;
  logic [ReqPktW-1:0]  host_pkt [HOST_NUM];

  logic                gst_req_vld;
  logic [ReqPktW-1:0]  gst_req_pkt;
  logic                gst_rsp_rdy;

  logic                win_vld;
  logic [IdxW-1:0]     win_idx;
  logic [IdxW-1:0]     cand_idx;
  int unsigned         cand;

  // Flatten the interface arrays so the control logic can index them by grant.
  for (genvar g = 0; g < HOST_NUM; g++) begin : g_host
    assign host_vld[g]                 = host_bti_req_slvs[g].vld;
    assign host_pkt[g]                 = host_bti_req_slvs[g].pkt;
    assign host_bti_req_slvs[g].rdy    = host_rdy[g];
    assign host_bti_rsp_msts[g].vld    = host_rsp_vld[g];
    // Response payload is broadcast; only vld singles out the owner.
    assign host_bti_rsp_msts[g].pkt    = gst_bti_rsp_slv.pkt;
    assign host_rsp_rdy[g]             = host_bti_rsp_msts[g].rdy;
  end

  assign gst_bti_req_mst.vld = gst_req_vld;
  assign gst_bti_req_mst.pkt = gst_req_pkt;
  assign gst_bti_rsp_slv.rdy = gst_rsp_rdy;

  // Pick the first requesting host at or above rr_ptr, wrapping modulo HOST_NUM.
  always_comb begin
    win_vld  = 1'b0;
    win_idx  = '0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned i = 0; i < HOST_NUM; i++) begin
      cand     = (32'(rr_ptr_q) + i) % HOST_NUM;
      cand_idx = IdxW'(cand);
      if (!win_vld && host_vld[cand_idx]) begin
        win_vld = 1'b1;
        win_idx = cand_idx;
      end
    end
  end

  // Next-state and output decode; everything defaults to idle/zero.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    rr_ptr_d     = rr_ptr_q;
    host_rdy     = '0;
    host_rsp_vld = '0;
    gst_req_vld  = 1'b0;
    gst_req_pkt  = '0;
    gst_rsp_rdy  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (win_vld) begin
          grant_d = win_idx;
          state_d = StReq;
        end
      end
      StReq: begin
        gst_req_vld       = 1'b1;
        gst_req_pkt       = host_pkt[grant_q];
        host_rdy[grant_q] = gst_bti_req_mst.rdy;
        if (gst_bti_req_mst.rdy) begin
          state_d = StRsp;
        end
      end
      StRsp: begin
        host_rsp_vld[grant_q] = gst_bti_rsp_slv.vld;
        gst_rsp_rdy           = host_rsp_rdy[grant_q];
        if (gst_bti_rsp_slv.vld && host_rsp_rdy[grant_q]) begin
          rr_ptr_d = (grant_q == IdxW'(HOST_NUM - 1)) ? '0 : grant_q + IdxW'(1);
          state_d  = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State, grant and priority pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: tb/tb_bti_arb.sv
// Self-checking bench for bti_arb with two hosts: directed vector table,
// hand-written corner sequences and a randomized run against a reference model.

module tb_bti_arb;

  localparam int unsigned NH = 2;

  typedef struct packed {
    logic [3:0]  tid;
    logic        cmd;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strobe;
  } req_pkt_t;

  typedef struct packed {
    logic [3:0]  tid;
    logic [31:0] data;
    logic        ok;
  } rsp_pkt_t;

  typedef struct {
    logic [1:0] vld;
    logic       g_rdy;
    logic       g_rvld;
    logic [1:0] r_rdy;
    logic [5:0] exp_o;   // {g_req_vld, h_rdy[1:0], h_rsp_vld[1:0], g_rsp_rdy}
    int         exp_pkt; // 0: zero, 1: host0 packet, 2: host1 packet
    int         exp_rr;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  logic [NH-1:0] h_vld, h_rdy, h_rsp_vld, h_rsp_rdy;
  req_pkt_t      h_pkt [NH];
  rsp_pkt_t      h_rsp_pkt [NH];
  logic          g_req_vld, g_req_rdy, g_rsp_vld, g_rsp_rdy;
  req_pkt_t      g_req_pkt;
  rsp_pkt_t      g_rsp_pkt;

  bti_req_if_t #(.BTI_AW(32), .BTI_DW(32), .BTI_TW(4)) host_req_if [NH] ();
  bti_rsp_if_t #(.BTI_DW(32), .BTI_TW(4))              host_rsp_if [NH] ();
  bti_req_if_t #(.BTI_AW(32), .BTI_DW(32), .BTI_TW(4)) gst_req_if ();
  bti_rsp_if_t #(.BTI_DW(32), .BTI_TW(4))              gst_rsp_if ();

  for (genvar g = 0; g < NH; g++) begin : g_if
    assign host_req_if[g].vld = h_vld[g];
    assign host_req_if[g].pkt = h_pkt[g];
    assign h_rdy[g]           = host_req_if[g].rdy;
    assign h_rsp_vld[g]       = host_rsp_if[g].vld;
    assign h_rsp_pkt[g]       = host_rsp_if[g].pkt;
    assign host_rsp_if[g].rdy = h_rsp_rdy[g];
  end

  assign gst_req_if.rdy = g_req_rdy;
  assign g_req_vld      = gst_req_if.vld;
  assign g_req_pkt      = gst_req_if.pkt;
  assign gst_rsp_if.vld = g_rsp_vld;
  assign gst_rsp_if.pkt = g_rsp_pkt;
  assign g_rsp_rdy      = gst_rsp_if.rdy;

  bti_arb #(
    .BTI_AW   (32),
    .BTI_DW   (32),
    .BTI_TW   (4),
    .HOST_NUM (NH)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .host_bti_req_slvs (host_req_if),
    .host_bti_rsp_msts (host_rsp_if),
    .gst_bti_req_mst   (gst_req_if),
    .gst_bti_rsp_slv   (gst_rsp_if)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  function automatic logic [5:0] obs();
    return {g_req_vld, h_rdy, h_rsp_vld, g_rsp_rdy};
  endfunction

  task automatic do_reset();
    rst_n     = 1'b0;
    h_vld     = '0;
    h_rsp_rdy = '0;
    g_req_rdy = 1'b0;
    g_rsp_vld = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  vec_t vecs [14];

  initial begin
    req_pkt_t   p;
    logic [5:0] e_o;
    logic [1:0] e_hrdy, e_hrsp;
    logic       e_gvld, e_grrdy;
    req_pkt_t   e_pkt;
    int         ngr, nreq, cyc, gi, nxt;
    int         cnt [2];
    bit         chk_rr;
    int         m_owner, m_ptr;
    bit         m_sent;
    logic [1:0] drop;

    // Stimulus packets for the directed parts.
    h_pkt[0]  = '{tid: 4'd3, cmd: 1'b0, addr: 32'h1000, data: 32'h0, strobe: 4'hf};
    h_pkt[1]  = '{tid: 4'd5, cmd: 1'b1, addr: 32'h2000, data: 32'h1234_5678, strobe: 4'h3};
    g_rsp_pkt = '{tid: 4'd3, data: 32'hDEAD_BEEF, ok: 1'b1};

    //            vld    grdy  grvld rrdy   exp_o       pkt rr
    vecs[0]  = '{2'b01, 1'b0, 1'b1, 2'b00, 6'b0_00_00_0, 0, 0}; // stray rsp in IDLE
    vecs[1]  = '{2'b01, 1'b0, 1'b0, 2'b00, 6'b1_00_00_0, 1, 0}; // guest wait 1
    vecs[2]  = '{2'b01, 1'b0, 1'b0, 2'b00, 6'b1_00_00_0, 1, 0}; // guest wait 2
    vecs[3]  = '{2'b01, 1'b1, 1'b0, 2'b00, 6'b1_01_00_0, 1, 0}; // handshake
    vecs[4]  = '{2'b10, 1'b1, 1'b1, 2'b00, 6'b0_00_01_0, 0, 0}; // back-pressure x5
    vecs[5]  = '{2'b10, 1'b1, 1'b1, 2'b00, 6'b0_00_01_0, 0, 0};
    vecs[6]  = '{2'b10, 1'b1, 1'b1, 2'b00, 6'b0_00_01_0, 0, 0};
    vecs[7]  = '{2'b10, 1'b1, 1'b1, 2'b00, 6'b0_00_01_0, 0, 0};
    vecs[8]  = '{2'b10, 1'b1, 1'b1, 2'b00, 6'b0_00_01_0, 0, 0};
    vecs[9]  = '{2'b10, 1'b0, 1'b1, 2'b01, 6'b0_00_01_1, 0, 0}; // response handshake
    vecs[10] = '{2'b10, 1'b0, 1'b0, 2'b00, 6'b0_00_00_0, 0, 1}; // IDLE, host1 wins
    vecs[11] = '{2'b10, 1'b1, 1'b1, 2'b11, 6'b1_10_00_0, 2, 1}; // REQ ignores guest rsp
    vecs[12] = '{2'b00, 1'b0, 1'b1, 2'b11, 6'b0_00_10_1, 0, 1};
    vecs[13] = '{2'b00, 1'b1, 1'b1, 2'b11, 6'b0_00_00_0, 0, 0}; // wrap to 0, stray rsp

    // Reset values with every input pushing towards activity.
    rst_n     = 1'b1;
    h_vld     = 2'b11;
    h_rsp_rdy = 2'b11;
    g_req_rdy = 1'b1;
    g_rsp_vld = 1'b1;
    #2 rst_n  = 1'b0;
    #1;
    chk("reset_out", 128'(obs()), 128'(6'b0));
    chk("reset_pkt", 128'(g_req_pkt), 128'(0));
    chk("reset_rr", 128'(dut.rr_ptr_q), 128'(0));
    chk("reset_grant", 128'(dut.grant_q), 128'(0));
    do_reset();

    // Directed vector table.
    for (int r = 0; r < 14; r++) begin
      @(negedge clk);
      h_vld     = vecs[r].vld;
      g_req_rdy = vecs[r].g_rdy;
      g_rsp_vld = vecs[r].g_rvld;
      h_rsp_rdy = vecs[r].r_rdy;
      #1;
      p = '0;
      if (vecs[r].exp_pkt == 1) p = h_pkt[0];
      if (vecs[r].exp_pkt == 2) p = h_pkt[1];
      chk($sformatf("vec%0d_out", r), 128'(obs()), 128'(vecs[r].exp_o));
      chk($sformatf("vec%0d_pkt", r), 128'(g_req_pkt), 128'(p));
      chk($sformatf("vec%0d_rr", r), 128'(dut.rr_ptr_q), 128'(vecs[r].exp_rr));
      chk($sformatf("vec%0d_rsp_pkt", r), 128'({h_rsp_pkt[1], h_rsp_pkt[0]}),
          128'({g_rsp_pkt, g_rsp_pkt}));
    end

    // Saturated requests: grants must alternate 0,1,0,1 starting from host0.
    do_reset();
    h_vld     = 2'b11;
    g_req_rdy = 1'b1;
    g_rsp_vld = 1'b1;
    h_rsp_rdy = 2'b11;
    ngr = 0; nreq = 0; cyc = 0; chk_rr = 1'b0;
    cnt[0] = 0; cnt[1] = 0;
    while (ngr < 8 && cyc < 100) begin
      @(negedge clk);
      #1;
      cyc++;
      if (chk_rr) begin
        chk($sformatf("sat_rr%0d", ngr), 128'(dut.rr_ptr_q), 128'(ngr % 2));
        chk_rr = 1'b0;
      end
      if (g_req_vld && g_req_rdy) begin
        chk($sformatf("sat_grant%0d", nreq), 128'(h_rdy), 128'(2'b01 << (nreq % 2)));
        gi = h_rdy[1] ? 1 : 0;
        cnt[gi]++;
        nreq++;
      end
      if (g_rsp_vld && g_rsp_rdy) begin
        ngr++;
        chk_rr = 1'b1;
      end
    end
    @(negedge clk);
    #1;
    if (chk_rr) chk("sat_rr_last", 128'(dut.rr_ptr_q), 128'(ngr % 2));
    chk("sat_done", 128'(ngr), 128'(8));
    chk("sat_cnt0", 128'(cnt[0]), 128'(4));
    chk("sat_cnt1", 128'(cnt[1]), 128'(4));

    // Reset in RSP, then host1 must reach the guest one cycle after its vld.
    do_reset();
    @(negedge clk);
    h_vld = 2'b01;
    @(negedge clk);
    g_req_rdy = 1'b1;
    #1;
    chk("rst_seq_req", 128'(obs()), 128'(6'b1_01_00_0));
    @(negedge clk);
    h_vld     = 2'b00;
    g_req_rdy = 1'b0;
    g_rsp_vld = 1'b1;
    h_rsp_rdy = 2'b11;
    #1;
    chk("rst_seq_rsp", 128'(obs()), 128'(6'b0_00_01_1));
    #1 rst_n = 1'b0;
    #1;
    chk("rst_async_out", 128'(obs()), 128'(6'b0));
    chk("rst_async_pkt", 128'(g_req_pkt), 128'(0));
    chk("rst_async_rr", 128'(dut.rr_ptr_q), 128'(0));
    @(negedge clk);
    rst_n     = 1'b1;
    h_vld     = 2'b10;
    g_rsp_vld = 1'b0;
    h_rsp_rdy = 2'b00;
    g_req_rdy = 1'b1;
    #1;
    chk("post_rst_idle", 128'(obs()), 128'(6'b0));
    @(negedge clk);
    #1;
    chk("post_rst_req", 128'(obs()), 128'(6'b1_10_00_0));
    chk("post_rst_pkt", 128'(g_req_pkt), 128'(h_pkt[1]));
    @(negedge clk);
    h_vld     = 2'b00;
    g_req_rdy = 1'b0;
    g_rsp_vld = 1'b1;
    h_rsp_rdy = 2'b11;
    #1;
    chk("post_rst_rsp", 128'(obs()), 128'(6'b0_00_10_1));

    // Randomized traffic against a transaction-level reference model.
    do_reset();
    m_owner = -1; m_sent = 1'b0; m_ptr = 0; drop = '0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      for (int i = 0; i < NH; i++) begin
        if (drop[i]) begin
          h_vld[i] = 1'b0;
          drop[i]  = 1'b0;
        end
        if (!h_vld[i] && ($urandom_range(2) == 0)) begin
          h_vld[i]        = 1'b1;
          h_pkt[i].tid    = 4'($urandom);
          h_pkt[i].cmd    = 1'($urandom);
          h_pkt[i].addr   = $urandom;
          h_pkt[i].data   = $urandom;
          h_pkt[i].strobe = 4'($urandom);
        end
      end
      g_req_rdy      = 1'($urandom);
      g_rsp_vld      = 1'($urandom);
      h_rsp_rdy      = 2'($urandom);
      g_rsp_pkt.tid  = 4'($urandom);
      g_rsp_pkt.data = $urandom;
      g_rsp_pkt.ok   = 1'($urandom);
      #1;
      e_gvld = 1'b0; e_hrdy = '0; e_hrsp = '0; e_grrdy = 1'b0; e_pkt = '0; nxt = -1;
      if (m_owner < 0) begin
        for (int k = 0; k < NH; k++) begin
          gi = (m_ptr + k) % NH;
          if (nxt < 0 && h_vld[gi]) nxt = gi;
        end
      end else if (!m_sent) begin
        e_gvld = 1'b1;
        e_pkt  = h_pkt[m_owner];
        if (g_req_rdy) e_hrdy[m_owner] = 1'b1;
      end else begin
        if (g_rsp_vld) e_hrsp[m_owner] = 1'b1;
        e_grrdy = h_rsp_rdy[m_owner];
      end
      e_o = {e_gvld, e_hrdy, e_hrsp, e_grrdy};
      chk($sformatf("rnd%0d_out", c), 128'(obs()), 128'(e_o));
      chk($sformatf("rnd%0d_pkt", c), 128'(g_req_pkt), 128'(e_pkt));
      chk($sformatf("rnd%0d_rsp_pkt", c), 128'({h_rsp_pkt[1], h_rsp_pkt[0]}),
          128'({g_rsp_pkt, g_rsp_pkt}));
      if (m_owner < 0) begin
        m_owner = nxt;
        m_sent  = 1'b0;
      end else if (!m_sent) begin
        if (g_req_rdy) begin
          m_sent        = 1'b1;
          drop[m_owner] = 1'b1;
        end
      end else if (g_rsp_vld && h_rsp_rdy[m_owner]) begin
        m_ptr   = (m_owner + 1) % NH;
        m_owner = -1;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bti_arb.md
# bti_arb

Round-robin N-to-1 BTI arbiter: several BTI hosts (for example the instruction-fetch and load/store ports) share one BTI guest (a downstream bus, memory or `bti_demux`). It is the counterpart of `bti_demux`: many request slave ports fan in to one request master. It allows one outstanding transaction at a time and routes the guest response back to the host that issued the request.

## Interface
- `BTI_AW`, default 32: address width.
- `BTI_DW`, default 32: data width; strobe width is `BTI_DW/8`.
- `HOST_NUM`, default 2: number of host ports; must be at least 1.
- `clk`  input  1  clock; all state changes on the rising edge.
- `rst_n`  input  1  reset; asynchronous, active-low.
- `host_bti_req_slvs[HOST_NUM]`  `bti_req_if_t.slv`  interface array  requests from the hosts.
- `host_bti_rsp_msts[HOST_NUM]`  `bti_rsp_if_t.mst`  interface array  responses to the hosts.
- `gst_bti_req_mst`  `bti_req_if_t.mst`  interface  request to the guest.
- `gst_bti_rsp_slv`  `bti_rsp_if_t.slv`  interface  response from the guest.

## Operation
- **State machine states:** `IDLE`, `REQ`, `RSP`.
- **Registers:**
  - `state`
  - `grant`: index of the host being served, `$clog2(HOST_NUM)` bits, minimum 1.
  - `rr_ptr`: index of the current highest-priority host.
- **IDLE:**
  - If any host request `vld` is high, the winner is the first host with `vld` high, searching upward from `rr_ptr` with modulo-`HOST_NUM` wrap.
  - The winner is latched into `grant`, and the next state is `REQ`.
  - No host `rdy` is asserted.
- **REQ:**
  - `gst_bti_req_mst.vld` = 1.
  - `gst_bti_req_mst.pkt` = `host[grant].pkt`, with `tid`, `cmd`, `addr`, `data` and `strobe` passed unmodified.
  - `host[grant].rdy` = `gst_bti_req_mst.rdy`.
  - On the guest request handshake, the next state is `RSP`.
- **RSP:**
  - `host[grant].rsp.vld` = `gst_bti_rsp_slv.vld`.
  - `gst_bti_rsp_slv.rdy` = `host[grant].rsp.rdy`.
  - On the response handshake:
    - `rr_ptr` <= (`grant` + 1) mod `HOST_NUM`.
    - The next state is `IDLE`.
- **Response packet:** the guest response `pkt` (`tid`, `data`, `ok`) is broadcast to every host response port. `vld` is asserted only on the granted port.
- **Non-granted hosts:** request `rdy` = 0 and response `vld` = 0 at all times.
- **Guest outputs outside their active state:**
  - `gst_bti_req_mst.vld` = 0 and `gst_bti_req_mst.pkt` = 0 outside `REQ`.
  - `gst_bti_rsp_slv.rdy` = 0 outside `RSP`. A stray guest response is back-pressured, not dropped.
- **Host protocol rule:** a host holds `vld` and `pkt` stable until it sees `rdy`. The arbiter does not re-arbitrate in `REQ` or `RSP`, even if the granted host drops `vld`; that case is a protocol violation and its behaviour is undefined.
- **`HOST_NUM` = 1:** degenerates to a registered pass-through with the same state machine.

## Timing
- **Reset values:**
  - `state` = `IDLE`, `grant` = 0, `rr_ptr` = 0.
  - All host `rdy` = 0 and all host response `vld` = 0.
  - Guest request `vld` = 0, guest request `pkt` = 0, guest response `rdy` = 0.
- **Latency:**
  - Host `vld` rising in cycle N (state `IDLE`) gives guest `vld` in cycle N+1.
  - The host request handshake occurs in the same cycle as the guest request handshake (combinational `rdy`).
  - The response path is combinational: guest response `vld` in cycle M reaches the host in cycle M.
- **Throughput:** minimum 3 cycles per transaction (`IDLE`, `REQ`, `RSP` each at least 1 cycle). `RSP` exits to `IDLE` and never jumps directly to `REQ`.
- **Simultaneous requests:** exactly one grant per arbitration cycle; the losers keep `vld` high and wait.
- **Priority update:** `rr_ptr` updates only on response-handshake completion. Repeated requests from the same host therefore alternate fairly with the other hosts.
- **Wrap-around:** with `grant` = `HOST_NUM`-1, `rr_ptr` becomes 0.
- **Reset mid-transaction:** asserting `rst_n` low in `REQ` or `RSP` immediately forces all reset values. An in-flight guest transaction is abandoned, and the guest must be reset with it.

## Test plan
- **Single request, `HOST_NUM`=2:** host0 sends `addr`=0x1000, `tid`=3; the guest accepts after 2 wait cycles and responds with `data`=0xDEADBEEF, `ok`=1.
  - Required: host0 sees `rdy` in the same cycle as the guest handshake.
  - Required: host0 sees response `vld` with `tid`=3, `data`=0xDEADBEEF; host1 never sees `rdy` or `vld`.
- **Simultaneous requests after reset:** host0 and host1 both raise `vld`.
  - Required: host0 is served first, then host1.
  - Required: `rr_ptr` is 1 after the first response, then 0 after the second.
- **Saturated requests:** both hosts assert `vld` for 8 transactions.
  - Required: grants alternate 0,1,0,1,... with exactly 4 grants each.
- **Response back-pressure:** the granted host holds response `rdy`=0 for 5 cycles.
  - Required: guest response `rdy`=0 for those 5 cycles; state stays `RSP`; no new guest request is issued.
- **Stray response:** the guest asserts response `vld` while in `IDLE`.
  - Required: guest response `rdy`=0 and no host response `vld`.
- **Reset during `RSP`:** assert reset while in `RSP`.
  - Required: all outputs return to their reset values asynchronously.
  - Required: the next request from host1 is granted and reaches the guest one cycle after its `vld`.
